// File: rtl/dve_pkg.sv
// Shared definitions for the simulation controller block.
//   STATE_W : encoding width of the controller state
//   state_e : controller states HOLD (cores in reset), RUN (cores executing),
//             DONE (run finished, waiting for restart)
package dve_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dve_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset (count returns to 0)
//   clear_i : synchronous clear, takes priority over en_i
//   en_i    : increment by one per clock while below all-ones
//   count_o : current count value
module dve_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Holding at all-ones keeps the count from wrapping back to zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/dve_sim_ctrl.sv
// Simulation run controller: holds the cores in reset for RST_CYCLES clocks,
// lets them run while counting cycles, and finishes when every core has
// halted (or, optionally, when MAX_CYCLES run cycles have elapsed).
// Optional feature macro: DVE_SIM_CTRL_TIMEOUT_EN enables the run timeout;
// without it timeout is tied to 0 and MAX_CYCLES is only range-checked.
// Ports:
//   clk         : clock
//   reset       : asynchronous active-low reset
//   restart     : single-cycle request to rerun, honoured only in DONE
//   core_halt   : per-core halt level
//   core_fail   : per-core failure flag, qualified by core_halt
//   core_reset  : active-high reset to the cores (high while in HOLD)
//   cycle_count : number of RUN cycles elapsed, saturating
//   done        : high for the whole of DONE
//   finish      : one-cycle pulse on DONE entry
//   pass        : run finished without timeout and without any failure
//   timeout     : run ended because the cycle limit was reached
//   halted      : sticky per-core halt record for the current run
module dve_sim_ctrl
  import dve_pkg::*;
#(
  parameter int CNT_WIDTH  = 32,
  parameter int NUM_CORES  = 1,
  parameter int RST_CYCLES = 4,
  parameter int MAX_CYCLES = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 restart,
  input  logic [NUM_CORES-1:0] core_halt,
  input  logic [NUM_CORES-1:0] core_fail,
  output logic                 core_reset,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic                 done,
  output logic                 finish,
  output logic                 pass,
  output logic                 timeout,
  output logic [NUM_CORES-1:0] halted
);

  localparam int HOLD_W = $clog2(RST_CYCLES + 1);

  if (RST_CYCLES < 1) begin : g_bad_rst_cycles
    $error("dve_sim_ctrl: RST_CYCLES must be >= 1");
  end

  if ((MAX_CYCLES < 1) ||
      ((CNT_WIDTH < 32) && (longint'(MAX_CYCLES) >= (longint'(1) << CNT_WIDTH)))) begin : g_bad_max_cycles
    $error("dve_sim_ctrl: MAX_CYCLES must be >= 1 and < 2**CNT_WIDTH");
  end

  state_e               state_q, state_d;
  logic [HOLD_W-1:0]    holdCnt;
  logic [NUM_CORES-1:0] halted_q, halted_d;
  logic [NUM_CORES-1:0] failed_q, failed_d;
  logic                 finish_q, finish_d;
  logic                 allHalt;
  logic                 timeoutHit;
  logic                 restartDone;

  // Cores already recorded as halted plus those halting this cycle.
  assign allHalt     = &(halted_q | core_halt);
  assign restartDone = (state_q == DONE) && restart;

  // Counts clocks spent in HOLD; held at zero everywhere else so every
  // HOLD visit starts from a fresh count.
  dve_sat_counter #(.WIDTH(HOLD_W)) holdCounter (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clear_i (state_q != HOLD),
    .en_i    (state_q == HOLD),
    .count_o (holdCnt)
  );

  // Cleared on the restart edge so cycle_count reads 0 throughout HOLD.
  dve_sat_counter #(.WIDTH(CNT_WIDTH)) cycleCounter (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clear_i (restartDone),
    .en_i    (state_q == RUN),
    .count_o (cycle_count)
  );

`ifdef DVE_SIM_CTRL_TIMEOUT_EN
  logic timeout_q, timeout_d;

  // The limit is reached on the edge where the count steps to MAX_CYCLES.
  assign timeoutHit = (cycle_count == CNT_WIDTH'(MAX_CYCLES - 1));

  // All-halt has priority, so a simultaneous halt leaves timeout low.
  always_comb begin
    timeout_d = timeout_q;
    if ((state_q == RUN) && !allHalt && timeoutHit) begin
      timeout_d = 1'b1;
    end else if (restartDone) begin
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeoutHit = 1'b0;
  assign timeout    = 1'b0;
`endif

  // Next-state logic; halt/fail records only update while running and are
  // wiped when a restart sends the controller back to HOLD.
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    failed_d = failed_q;
    finish_d = 1'b0;
    case (state_q)
      HOLD: begin
        if (holdCnt == HOLD_W'(RST_CYCLES - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        halted_d = halted_q | core_halt;
        failed_d = failed_q | (core_halt & core_fail);
        if (allHalt || timeoutHit) begin
          state_d  = DONE;
          finish_d = 1'b1;
        end
      end
      DONE: begin
        if (restart) begin
          state_d  = HOLD;
          halted_d = '0;
          failed_d = '0;
        end
      end
      default: begin
        state_d = HOLD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= HOLD;
      halted_q <= '0;
      failed_q <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      failed_q <= failed_d;
      finish_q <= finish_d;
    end
  end

  assign core_reset = (state_q == HOLD);
  assign done       = (state_q == DONE);
  assign finish     = finish_q;
  assign halted     = halted_q;
  assign pass       = done & ~timeout & ~|failed_q;

endmodule

// File: tb/tb_dve_sim_ctrl.sv
// Self-checking bench for dve_sim_ctrl with two cores, an 8-bit cycle
// counter, RST_CYCLES=4 and MAX_CYCLES=13. Expected end-of-run results are
// queued when a run is launched and popped when the DUT pulses finish.
module tb_dve_sim_ctrl;

  localparam int CW = 8;
  localparam int NC = 2;
  localparam int RC = 4;
  localparam int MC = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          restart;
  logic [NC-1:0] coreHalt;
  logic [NC-1:0] coreFail;
  logic          coreReset;
  logic [CW-1:0] cycleCount;
  logic          done;
  logic          finish;
  logic          pass;
  logic          timeout;
  logic [NC-1:0] halted;

  int numCompared   = 0;
  int numMismatched = 0;

  typedef struct {
    logic [CW-1:0] count;
    logic          timeout;
    logic          pass;
    logic [NC-1:0] halted;
  } expect_t;

  expect_t expQ[$];

  dve_sim_ctrl #(
    .CNT_WIDTH  (CW),
    .NUM_CORES  (NC),
    .RST_CYCLES (RC),
    .MAX_CYCLES (MC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .restart     (restart),
    .core_halt   (coreHalt),
    .core_fail   (coreFail),
    .core_reset  (coreReset),
    .cycle_count (cycleCount),
    .done        (done),
    .finish      (finish),
    .pass        (pass),
    .timeout     (timeout),
    .halted      (halted)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Hard stop in case something upstream stalls outside the bounded loops.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NC-1:0] halt, input logic [NC-1:0] fail,
                               input logic rst);
    coreHalt = halt;
    coreFail = fail;
    restart  = rst;
  endtask

  // Counts rising edges until core_reset drops, then checks the run starts at 0.
  task automatic waitHold();
    int edges;
    edges = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      edges++;
      if (!coreReset) break;
    end
    checkOutput("holdEdges", edges, RC);
    checkOutput("runStartCount", cycleCount, 0);
  endtask

  // Drives one run: halt/fail/restart pulses at given run-cycle indices
  // (-1 = never), then compares the DUT's DONE state with the queued result.
  task automatic runUntilFinish(input int budget, input int halt0At, input int halt1At,
                                input int failAt, input int restartAt);
    bit      seen;
    expect_t e;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      applyStimulus({k == halt1At, k == halt0At}, {NC{k == failAt}}, k == restartAt);
      tick();
      if (finish) begin
        seen = 1'b1;
        break;
      end
    end
    applyStimulus('0, '0, 1'b0);
    if (!seen) begin
      checkOutput("finishSeen", 0, 1);
    end else if (expQ.size() == 0) begin
      checkOutput("scoreboardHasEntry", 0, 1);
    end else begin
      e = expQ.pop_front();
      checkOutput("doneCount", cycleCount, e.count);
      checkOutput("doneTimeout", timeout, e.timeout);
      checkOutput("donePass", pass, e.pass);
      checkOutput("doneHalted", halted, e.halted);
      checkOutput("doneLevel", done, 1);
      checkOutput("doneCoreReset", coreReset, 0);
    end
    tick();
    checkOutput("finishOnePulse", finish, 0);
    checkOutput("doneHeld", done, 1);
  endtask

  // Restart pulse from DONE; HOLD must be entered on the very next edge.
  task automatic doRestart();
    applyStimulus('0, '0, 1'b1);
    tick();
    applyStimulus('0, '0, 1'b0);
    checkOutput("restartCoreReset", coreReset, 1);
    checkOutput("restartHalted", halted, 0);
    checkOutput("restartCount", cycleCount, 0);
    checkOutput("restartDone", done, 0);
    checkOutput("restartTimeout", timeout, 0);
    waitHold();
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus('0, '0, 1'b0);
    #3;
    checkOutput("rstCoreReset", coreReset, 1);
    checkOutput("rstDone", done, 0);
    checkOutput("rstFinish", finish, 0);
    checkOutput("rstCount", cycleCount, 0);
    checkOutput("rstHalted", halted, 0);
    checkOutput("rstTimeout", timeout, 0);
    checkOutput("rstPass", pass, 0);

    @(posedge clk);
    #1;
    reset = 1'b1;
    waitHold();

    // Staggered single-cycle halts must be remembered; restart in RUN ignored.
    expQ.push_back('{count: 8'd7, timeout: 1'b0, pass: 1'b1, halted: 2'b11});
    runUntilFinish(40, 3, 6, -1, 2);
    doRestart();

`ifdef DVE_SIM_CTRL_TIMEOUT_EN
    expQ.push_back('{count: 8'd13, timeout: 1'b1, pass: 1'b0, halted: 2'b00});
    runUntilFinish(30, -1, -1, -1, -1);
    doRestart();
`else
    for (int i = 0; i < 20; i++) tick();
    checkOutput("noTimeoutDone", done, 0);
    checkOutput("noTimeoutCoreReset", coreReset, 0);
    checkOutput("noTimeoutFlag", timeout, 0);
    checkOutput("noTimeoutCount", cycleCount, 20);
    for (int i = 0; i < 240; i++) tick();
    checkOutput("saturatedCount", cycleCount, 8'hFF);
    expQ.push_back('{count: 8'hFF, timeout: 1'b0, pass: 1'b1, halted: 2'b11});
    runUntilFinish(5, 0, 0, -1, -1);
    doRestart();
`endif

    // Final halt with failure lands on the timeout cycle: all-halt wins.
    expQ.push_back('{count: 8'd13, timeout: 1'b0, pass: 1'b0, halted: 2'b11});
    runUntilFinish(30, 12, 2, 12, -1);
    doRestart();

    // Immediate all-halt; pass shows the earlier failure record was cleared.
    expQ.push_back('{count: 8'd1, timeout: 1'b0, pass: 1'b1, halted: 2'b11});
    runUntilFinish(5, 0, 0, -1, -1);
    doRestart();

    // Asynchronous abort in the middle of a run.
    applyStimulus(2'b01, '0, 1'b0);
    tick();
    applyStimulus('0, '0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("midRunCount", cycleCount, 5);
    checkOutput("midRunHalted", halted, 2'b01);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abortCoreReset", coreReset, 1);
    checkOutput("abortCount", cycleCount, 0);
    checkOutput("abortHalted", halted, 0);
    checkOutput("abortDone", done, 0);
    checkOutput("abortFinish", finish, 0);
    checkOutput("abortTimeout", timeout, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    waitHold();

    checkOutput("scoreboardDrained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
